// File: rtl/mips_pkg.sv
// Shared types and ISA constants for the multicycle MIPS controller.
package mips_pkg;

  // One state per cycle of the multicycle sequence.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU op class from the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes to the datapath
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU op class plus R-type funct to the ALU control code.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Unknown funct falls back to add rather than trapping.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control
);

  state_t     state_q, state_d;
  logic       pc_write, branch, illegal;
  logic       mem_write_s, ir_write_s, reg_write_s;
  logic [1:0] alu_op;
  logic [2:0] dec_ctrl;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (dec_ctrl)
  );

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b0;
    iord        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_s = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch target into alu_out.
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Write enables are gated by reset so a half-done instruction cannot commit.
  always_comb begin
    pc_en       = (pc_write | (branch & zero)) & ~reset;
    mem_write   = mem_write_s & ~reset;
    ir_write    = ir_write_s  & ~reset;
    reg_write   = reg_write_s & ~reset;
    alu_control = illegal ? 3'b000 : dec_ctrl;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction cycle-by-cycle expectations built from the ISA rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, zero;
  logic [5:0] op, funct;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  int n_chk = 0;
  int n_fail = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control)
  );

  always #5 clk = ~clk;

  // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,pc_src,alu_control}
  wire [14:0] obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                     alu_src_a, alu_src_b, pc_src, alu_control};
  localparam logic [14:0] EN_MASK = 15'b101_1001_0000_0000;

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input logic pe, ior, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ps, input logic [2:0] ac);
    return {pe, ior, mw, irw, rd, m2r, rw, sa, sb, ps, ac};
  endfunction

  function automatic int n_cycles(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle 'step' of instruction 'o'.
  function automatic logic [14:0] model(input logic [5:0] o, input logic [5:0] f,
                                        input logic z, input int step);
    if (step == 0) return pk(1,0,0,1,0,0,0,0,2'b01,2'b00,3'b010);
    if (step == 1) return pk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
    case (o)
      6'b100011: case (step)
        2: return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        3: return pk(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010);
        default: return pk(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010);
      endcase
      6'b101011: case (step)
        2: return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        default: return pk(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010);
      endcase
      6'b000000: case (step)
        2: return pk(0,0,0,0,0,0,0,1,2'b00,2'b00,r_alu(f));
        default: return pk(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010);
      endcase
      6'b001000: case (step)
        2: return pk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        default: return pk(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010);
      endcase
      6'b000100: return pk(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
      default:   return pk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010); // j
    endcase
  endfunction

  // Run one instruction from FETCH; optionally assert reset at cycle rst_at and abandon it.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int rst_at,
                           input int zmode);
    logic [14:0] exp;
    for (int s = 0; s < n_cycles(o); s++) begin
      @(negedge clk);
      op = o; funct = f;
      zero  = (zmode == 2) ? 1'($urandom) : zmode[0];
      reset = (s == rst_at);
      #1;
      exp = model(o, f, zero, s);
      if (reset) exp = exp & ~EN_MASK;
      chk($sformatf("op%06b_f%06b_s%0d%s", o, f, s, reset ? "_rst" : ""), obs, exp);
      if (s == rst_at) return;
    end
  endtask

  localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic bit is_known(input logic [5:0] o);
    foreach (OPS[i]) if (OPS[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [5:0] ro, rf;
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    // Two checked cycles in reset: FETCH state, write enables masked.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk($sformatf("reset_%0d", i), obs, model(6'b0, 6'b0, 1'b0, 0) & ~EN_MASK);
    end

    run_instr(6'b100011, 6'b000000, -1, 0);  // lw
    run_instr(6'b000000, 6'b101010, -1, 0);  // slt
    run_instr(6'b000100, 6'b000000, -1, 1);  // beq taken
    run_instr(6'b000100, 6'b000000, -1, 0);  // beq not taken
    run_instr(6'b101011, 6'b000000, -1, 0);  // sw
    run_instr(6'b000010, 6'b000000, -1, 0);  // j
    run_instr(6'b111111, 6'b000000, -1, 0);  // unknown -> nop
    run_instr(6'b101011, 6'b000000, 3, 0);   // reset during MEMWR
    run_instr(6'b100011, 6'b000000, -1, 0);  // resumes cleanly from FETCH
    run_instr(6'b000000, 6'b111111, -1, 0);  // unknown funct -> add

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do ro = 6'($urandom); while (is_known(ro));
      end else begin
        ro = OPS[$urandom_range(0, 5)];
      end
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 4)];
      run_instr(ro, rf, ($urandom_range(0, 9) == 0) ? $urandom_range(0, n_cycles(ro) - 1) : -1, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
